// File: rtl/median_partition_stage_if.sv
// Handshake/data bundle for one quickselect partition stage: cfg/pixel FIFO
// read side, next-stage cfg/pixel/median FIFO write side, plus status.
interface median_partition_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 11
);
  localparam int unsigned CFG_W = DATA_W + 2 * CNT_W;

  logic [CFG_W-1:0]  in_cfg;
  logic              in_cfg_empty;
  logic              in_cfg_rd;
  logic [DATA_W-1:0] in_px;
  logic              in_px_empty;
  logic              in_px_rd;
  logic [CFG_W-1:0]  out_cfg;
  logic              out_cfg_full;
  logic              out_cfg_wr;
  logic [DATA_W-1:0] out_px;
  logic              out_px_full;
  logic              out_px_wr;
  logic [DATA_W-1:0] out_med;
  logic              out_med_full;
  logic              out_med_wr;
  logic              busy;
  logic              err;

  modport slave (
    input  in_cfg, in_cfg_empty, in_px, in_px_empty,
           out_cfg_full, out_px_full, out_med_full,
    output in_cfg_rd, in_px_rd, out_cfg, out_cfg_wr, out_px, out_px_wr,
           out_med, out_med_wr, busy, err
  );

  modport master (
    output in_cfg, in_cfg_empty, in_px, in_px_empty,
           out_cfg_full, out_px_full, out_med_full,
    input  in_cfg_rd, in_px_rd, out_cfg, out_cfg_wr, out_px, out_px_wr,
           out_med, out_med_wr, busy, err
  );
endinterface

// File: rtl/median_partition_stage.sv
// One quickselect stage: 3-way partitions a pixel job around its pivot and either
// forwards the partition holding the median (with a new cfg) or emits the median.
module median_partition_stage #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned CNT_W         = 11,
  parameter int unsigned DEFAULT_PIVOT = 127,
  parameter int unsigned USE_DEF       = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  median_partition_stage_if.slave    bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DECIDE,
    S_SEND_CFG,
    S_SEND_PX,
    S_SEND_MED
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] pivot;
  logic [CNT_W-1:0]  size, pos, rcnt, lc, ec, gc, idx, next_size;
  logic              sel_larger;
  logic [DATA_W-1:0] lower_min, lower_max, larger_min, larger_max;
  logic [DATA_W-1:0] out_cfg_pivot;
  logic [CNT_W-1:0]  out_cfg_size, out_cfg_pos;
  logic [DATA_W-1:0] out_med_q;
  logic              err_q;

  logic [DATA_W-1:0] lower_buf  [DEPTH];
  logic [DATA_W-1:0] larger_buf [DEPTH];

  // cfg decode
  logic [DATA_W-1:0] cfg_pivot_raw, cfg_pivot;
  logic [CNT_W-1:0]  cfg_size, cfg_pos, cfg_size_cl;
  logic              cfg_bad;

  assign {cfg_pivot_raw, cfg_size, cfg_pos} = bus.in_cfg;
  assign cfg_pivot   = (USE_DEF != 0 && cfg_pivot_raw == '1) ? DATA_W'(DEFAULT_PIVOT)
                                                             : cfg_pivot_raw;
  assign cfg_size_cl = (cfg_size > DEPTH_C) ? DEPTH_C : cfg_size;
  // clamped size never exceeds raw size, so one test covers both rejection rules
  assign cfg_bad     = (cfg_size == '0) || (cfg_pos >= cfg_size_cl);

  // handshake qualifiers
  logic cfg_take, px_take, cfg_push, px_push, med_push;
  logic px_lower, px_larger, px_last;

  assign cfg_take  = (state == S_IDLE)     && !bus.in_cfg_empty;
  assign px_take   = (state == S_FILL)     && !bus.in_px_empty;
  assign cfg_push  = (state == S_SEND_CFG) && !bus.out_cfg_full;
  assign px_push   = (state == S_SEND_PX)  && !bus.out_px_full;
  assign med_push  = (state == S_SEND_MED) && !bus.out_med_full;
  assign px_lower  = bus.in_px < pivot;
  assign px_larger = bus.in_px > pivot;
  assign px_last   = (rcnt == size - ONE_C);

  // partition selection, evaluated in CNT_W+1 bits
  logic [CNT_W:0]    pos_w, lc_w, lce_w;
  logic              d_direct, d_sel_larger, d_resolved;
  logic [CNT_W-1:0]  d_next_pos, d_next_size;
  logic [DATA_W-1:0] d_min, d_max, d_med, d_pivot;
  logic [DATA_W:0]   d_sum;

  assign pos_w = {1'b0, pos};
  assign lc_w  = {1'b0, lc};
  assign lce_w = lc_w + {1'b0, ec};

  always_comb begin
    d_direct     = 1'b0;
    d_sel_larger = 1'b0;
    d_next_pos   = '0;
    d_next_size  = '0;
    d_min        = lower_min;
    d_max        = lower_max;
    if (pos_w < lc_w) begin
      d_next_pos  = pos;
      d_next_size = lc;
    end else if (pos_w < lce_w) begin
      d_direct = 1'b1;
    end else begin
      d_sel_larger = 1'b1;
      d_next_pos   = CNT_W'(pos_w - lce_w);
      d_next_size  = gc;
      d_min        = larger_min;
      d_max        = larger_max;
    end
    d_resolved = d_direct || (d_min == d_max);
    d_med      = d_direct ? pivot : d_min;
    // midpoint lies in [min,max) whenever min<max, so the next job strictly shrinks
    d_sum      = {1'b0, d_min} + {1'b0, d_max};
    d_pivot    = d_sum[DATA_W:1];
  end

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // next state and strobes
  logic in_cfg_rd_c, in_px_rd_c, out_cfg_wr_c, out_px_wr_c, out_med_wr_c;

  always_comb begin
    next_state   = state;
    in_cfg_rd_c  = 1'b0;
    in_px_rd_c   = 1'b0;
    out_cfg_wr_c = 1'b0;
    out_px_wr_c  = 1'b0;
    out_med_wr_c = 1'b0;
    case (state)
      S_IDLE: begin
        in_cfg_rd_c = 1'b1;
        if (cfg_take && !cfg_bad) next_state = S_FILL;
      end
      S_FILL: begin
        in_px_rd_c = 1'b1;
        if (px_take && px_last) next_state = S_DECIDE;
      end
      S_DECIDE:
        next_state = d_resolved ? S_SEND_MED : S_SEND_CFG;
      S_SEND_CFG: begin
        out_cfg_wr_c = cfg_push;
        if (cfg_push) next_state = S_SEND_PX;
      end
      S_SEND_PX: begin
        out_px_wr_c = px_push;
        if (px_push && idx == next_size - ONE_C) next_state = S_IDLE;
      end
      S_SEND_MED: begin
        out_med_wr_c = med_push;
        if (med_push) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
    // strobes drop combinationally the moment reset rises
    if (reset) begin
      in_cfg_rd_c  = 1'b0;
      in_px_rd_c   = 1'b0;
      out_cfg_wr_c = 1'b0;
      out_px_wr_c  = 1'b0;
      out_med_wr_c = 1'b0;
    end
  end

  // job datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pivot         <= '0;
      size          <= '0;
      pos           <= '0;
      rcnt          <= '0;
      lc            <= '0;
      ec            <= '0;
      gc            <= '0;
      idx           <= '0;
      next_size     <= '0;
      sel_larger    <= 1'b0;
      lower_min     <= '0;
      lower_max     <= '0;
      larger_min    <= '0;
      larger_max    <= '0;
      out_cfg_pivot <= '0;
      out_cfg_size  <= '0;
      out_cfg_pos   <= '0;
      out_med_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_take) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              pivot      <= cfg_pivot;
              size       <= cfg_size_cl;
              pos        <= cfg_pos;
              rcnt       <= '0;
              lc         <= '0;
              ec         <= '0;
              gc         <= '0;
              lower_min  <= '1;
              lower_max  <= '0;
              larger_min <= '1;
              larger_max <= '0;
            end
          end
        end
        S_FILL: begin
          if (px_take) begin
            rcnt <= rcnt + ONE_C;
            if (px_lower) begin
              lc <= lc + ONE_C;
              if (bus.in_px < lower_min) lower_min <= bus.in_px;
              if (bus.in_px > lower_max) lower_max <= bus.in_px;
            end else if (px_larger) begin
              gc <= gc + ONE_C;
              if (bus.in_px < larger_min) larger_min <= bus.in_px;
              if (bus.in_px > larger_max) larger_max <= bus.in_px;
            end else begin
              ec <= ec + ONE_C;
            end
          end
        end
        S_DECIDE: begin
          sel_larger <= d_sel_larger;
          next_size  <= d_next_size;
          idx        <= '0;
          if (d_resolved) begin
            out_med_q <= d_med;
          end else begin
            out_cfg_pivot <= d_pivot;
            out_cfg_size  <= d_next_size;
            out_cfg_pos   <= d_next_pos;
          end
        end
        S_SEND_PX: begin
          if (px_push) idx <= idx + ONE_C;
        end
        default: ;
      endcase
    end
  end

  // partition storage, no reset: contents are only read for the job that wrote them
  always_ff @(posedge clock) begin
    if (px_take && px_lower)  lower_buf[lc[IDX_W-1:0]]  <= bus.in_px;
    if (px_take && px_larger) larger_buf[gc[IDX_W-1:0]] <= bus.in_px;
  end

  assign bus.in_cfg_rd  = in_cfg_rd_c;
  assign bus.in_px_rd   = in_px_rd_c;
  assign bus.out_cfg_wr = out_cfg_wr_c;
  assign bus.out_px_wr  = out_px_wr_c;
  assign bus.out_med_wr = out_med_wr_c;
  assign bus.out_cfg    = {out_cfg_pivot, out_cfg_size, out_cfg_pos};
  assign bus.out_med    = out_med_q;
  assign bus.out_px     = (state != S_SEND_PX) ? '0 :
                          sel_larger ? larger_buf[idx[IDX_W-1:0]] : lower_buf[idx[IDX_W-1:0]];
  assign bus.busy       = (state != S_IDLE);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_median_partition_stage.sv
// Bench for median_partition_stage: FIFO models around the DUT, a queue-based
// quickselect reference per job, directed and randomized jobs, reset abort.
module tb_median_partition_stage;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned CFG_W  = DATA_W + 2 * CNT_W;

  logic clock;
  logic reset;

  median_partition_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  median_partition_stage #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W),
    .DEFAULT_PIVOT(127), .USE_DEF(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO models
  logic [CFG_W-1:0]  cfg_q[$];
  logic [DATA_W-1:0] px_q[$];
  logic [CFG_W-1:0]  got_cfg[$];
  logic [DATA_W-1:0] got_px[$];
  logic [DATA_W-1:0] got_med[$];
  int px_reads = 0;
  bit rnd_in = 0, rnd_out = 0, hold_px_full = 0;

  initial begin
    logic s_cfg_take, s_px_take, s_cfg_wr, s_px_wr, s_med_wr;
    logic [CFG_W-1:0] s_cfg;
    logic [DATA_W-1:0] s_px, s_med;
    bus.in_cfg = '0; bus.in_cfg_empty = 1'b1;
    bus.in_px  = '0; bus.in_px_empty  = 1'b1;
    bus.out_cfg_full = 1'b0; bus.out_px_full = 1'b0; bus.out_med_full = 1'b0;
    forever begin
      @(negedge clock);
      s_cfg_take = bus.in_cfg_rd && !bus.in_cfg_empty;
      s_px_take  = bus.in_px_rd && !bus.in_px_empty;
      s_cfg_wr = bus.out_cfg_wr; s_cfg = bus.out_cfg;
      s_px_wr  = bus.out_px_wr;  s_px  = bus.out_px;
      s_med_wr = bus.out_med_wr; s_med = bus.out_med;
      if (s_cfg_wr) check("cfg_wr_while_full", bus.out_cfg_full, 1'b0);
      if (s_px_wr)  check("px_wr_while_full",  bus.out_px_full,  1'b0);
      if (s_med_wr) check("med_wr_while_full", bus.out_med_full, 1'b0);
      @(posedge clock);
      if (!reset) begin
        if (s_cfg_take) void'(cfg_q.pop_front());
        if (s_px_take) begin void'(px_q.pop_front()); px_reads++; end
        if (s_cfg_wr) got_cfg.push_back(s_cfg);
        if (s_px_wr)  got_px.push_back(s_px);
        if (s_med_wr) got_med.push_back(s_med);
      end
      #1;
      bus.in_cfg       = (cfg_q.size() != 0) ? cfg_q[0] : '0;
      bus.in_cfg_empty = (cfg_q.size() == 0) || (rnd_in && $urandom_range(0, 2) == 0);
      bus.in_px        = (px_q.size() != 0) ? px_q[0] : '0;
      bus.in_px_empty  = (px_q.size() == 0) || (rnd_in && $urandom_range(0, 1) == 0);
      bus.out_cfg_full = rnd_out && $urandom_range(0, 2) == 0;
      bus.out_px_full  = hold_px_full || (rnd_out && $urandom_range(0, 1) == 0);
      bus.out_med_full = rnd_out && $urandom_range(0, 2) == 0;
    end
  end

  // reference model: quickselect step expressed over plain queues
  logic [DATA_W-1:0] job_px[$];
  logic [CFG_W-1:0]  exp_cfg[$];
  logic [DATA_W-1:0] exp_px[$];
  logic [DATA_W-1:0] exp_med[$];
  int exp_reads;
  bit exp_err = 0;
  int job_n = 0;

  task automatic add(input int v);
    job_px.push_back(DATA_W'(v));
  endtask

  task automatic model(input int p_raw, input int sz, input int pos);
    logic [DATA_W-1:0] lo[$], hi[$], sel[$];
    int p, szc, eq, np, mn, mx;
    exp_cfg.delete(); exp_px.delete(); exp_med.delete();
    exp_reads = 0;
    p   = (p_raw == 255) ? 127 : p_raw;
    szc = (sz > int'(DEPTH)) ? int'(DEPTH) : sz;
    if (sz == 0 || pos >= szc) begin
      exp_err = 1;
      return;
    end
    exp_reads = szc;
    eq = 0;
    for (int i = 0; i < szc; i++) begin
      if (int'(job_px[i]) < p)      lo.push_back(job_px[i]);
      else if (int'(job_px[i]) > p) hi.push_back(job_px[i]);
      else                          eq++;
    end
    if (pos < lo.size()) begin
      sel = lo; np = pos;
    end else if (pos < lo.size() + eq) begin
      exp_med.push_back(DATA_W'(p));
      return;
    end else begin
      sel = hi; np = pos - lo.size() - eq;
    end
    mn = 255; mx = 0;
    foreach (sel[i]) begin
      if (int'(sel[i]) < mn) mn = int'(sel[i]);
      if (int'(sel[i]) > mx) mx = int'(sel[i]);
    end
    if (mn == mx) exp_med.push_back(DATA_W'(mn));
    else begin
      exp_cfg.push_back({DATA_W'((mn + mx) / 2), CNT_W'(sel.size()), CNT_W'(np)});
      exp_px = sel;
    end
  endtask

  task automatic run_job(input int p, input int sz, input int pos);
    int r0;
    bit done;
    job_n++;
    model(p, sz, pos);
    got_cfg.delete(); got_px.delete(); got_med.delete();
    r0 = px_reads;
    cfg_q.push_back({DATA_W'(p), CNT_W'(sz), CNT_W'(pos)});
    for (int i = 0; i < exp_reads; i++) px_q.push_back(job_px[i]);
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clock);
      done = (cfg_q.size() == 0) && (px_q.size() == 0) && !bus.busy;
    end
    check($sformatf("j%0d_done", job_n), done, 1'b1);
    check($sformatf("j%0d_reads", job_n), px_reads - r0, exp_reads);
    check($sformatf("j%0d_err", job_n), bus.err, exp_err);
    check($sformatf("j%0d_n_med", job_n), got_med.size(), exp_med.size());
    check($sformatf("j%0d_n_cfg", job_n), got_cfg.size(), exp_cfg.size());
    check($sformatf("j%0d_n_px", job_n), got_px.size(), exp_px.size());
    for (int i = 0; i < exp_med.size() && i < got_med.size(); i++)
      check($sformatf("j%0d_med", job_n), got_med[i], exp_med[i]);
    for (int i = 0; i < exp_cfg.size() && i < got_cfg.size(); i++)
      check($sformatf("j%0d_cfg", job_n), got_cfg[i], exp_cfg[i]);
    for (int i = 0; i < exp_px.size() && i < got_px.size(); i++)
      check($sformatf("j%0d_px%0d", job_n, i), got_px[i], exp_px[i]);
  endtask

  task automatic rand_px(input int n, input int hi);
    job_px.delete();
    for (int i = 0; i < n; i++) add($urandom_range(0, hi));
  endtask

  initial begin
    bit done;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_strobes", {bus.in_cfg_rd, bus.in_px_rd, bus.out_cfg_wr, bus.out_px_wr,
                          bus.out_med_wr, bus.busy, bus.err}, '0);
    check("rst_out_cfg", bus.out_cfg, '0);
    check("rst_out_px", bus.out_px, '0);
    check("rst_out_med", bus.out_med, '0);
    @(posedge clock); #3 reset = 1'b0;

    // pivot lands on median; forward lower; larger all equal
    job_px.delete(); add(1); add(9); add(5); add(3); add(7); run_job(5, 5, 2);
    job_px.delete(); add(8); add(2); add(6); add(1); add(9); run_job(5, 5, 0);
    job_px.delete(); add(7); add(7); add(7); add(7);          run_job(0, 4, 3);

    // illegal cfgs, then a legal job still processed
    job_px.delete(); run_job(5, 0, 0);
    job_px.delete(); run_job(5, 4, 4);
    job_px.delete(); add(4); add(3); add(2); add(1);          run_job(3, 4, 1);

    // clamp: size 20 reads DEPTH pixels; pos beyond clamped size is rejected
    rand_px(20, 255); run_job(100, 20, 10);
    job_px.delete();  run_job(100, 20, 17);

    // all-ones pivot field selects the default pivot
    job_px.delete(); add(200); add(100); add(127); add(50); add(130); run_job(255, 5, 2);

    // full-depth jobs under random empty/full handshakes, then mixed random jobs
    rnd_in = 1; rnd_out = 1;
    for (int j = 0; j < 6; j++) begin
      rand_px(DEPTH, 255);
      run_job($urandom_range(0, 255), DEPTH, $urandom_range(0, DEPTH - 1));
    end
    for (int j = 0; j < 20; j++) begin
      int sz;
      sz = $urandom_range(1, 20);
      rand_px(20, ($urandom_range(0, 1) == 0) ? 7 : 255);
      run_job($urandom_range(0, 255), sz, $urandom_range(0, sz - 1));
    end
    rnd_in = 0; rnd_out = 0;

    // reset while stalled in the pixel send phase
    hold_px_full = 1;
    got_cfg.delete(); got_px.delete(); got_med.delete();
    cfg_q.push_back({8'd100, 6'd8, 6'd0});
    for (int i = 1; i <= 8; i++) px_q.push_back(DATA_W'(i * 10));
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      done = (got_cfg.size() == 1);
    end
    check("abort_cfg_sent", done, 1'b1);
    repeat (3) @(negedge clock);
    if (got_cfg.size() != 0) check("abort_cfg", got_cfg[0], {8'd45, 6'd8, 6'd0});
    check("stall_px_held", bus.out_px, 8'd10);
    check("stall_busy", bus.busy, 1'b1);
    @(posedge clock); #3 reset = 1'b1;
    #1;
    check("abort_strobes", {bus.in_cfg_rd, bus.in_px_rd, bus.out_cfg_wr, bus.out_px_wr,
                            bus.out_med_wr, bus.busy, bus.err}, '0);
    check("abort_out_px", bus.out_px, '0);
    cfg_q.delete(); px_q.delete(); hold_px_full = 0; exp_err = 0;
    repeat (2) @(posedge clock);
    check("abort_no_px_wr", got_px.size(), 0);
    #3 reset = 1'b0;
    job_px.delete(); add(1); add(9); add(5); add(3); add(7); run_job(5, 5, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
